// File: rtl/data_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_tx
// Description : Source side of a level-qualified clock-domain crossing.
//               Each accepted word is put on unsync_bus. bus_enable is then
//               held high for HOLD_CYCLES cycles and low for GAP_CYCLES
//               cycles, so a multi-flop synchronizer on the destination side
//               can sample a stable bus.
//
// Parameters  : BUS_WIDTH   - width of the data word
//               HOLD_CYCLES - cycles bus_enable stays high per word (>= 1)
//               GAP_CYCLES  - cycles bus_enable stays low after a word (>= 1)
//
// Ports       : src_clk    (in)  single clock, rising edge
//               src_rst    (in)  synchronous active-high reset
//               in_data    (in)  word to send
//               in_valid   (in)  in_data is valid
//               in_ready   (out) a word can be accepted this cycle
//               unsync_bus (out) registered data toward the synchronizer
//               bus_enable (out) registered level qualifier, straight from a flop
//               busy       (out) FSM is not IDLE
//
// Option      : `define DATA_SYNC_TX_SKID_EN adds a one-entry holding buffer.
//               A word can then be accepted during HOLD/GAP and launched
//               back-to-back without an IDLE cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                 src_clk,
    input  logic                 src_rst,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy
);

    localparam int c_MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_HOLD_END = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_END  = c_CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_CNT_W-1:0]     r_cnt_q,   w_cnt_d;
    logic [BUS_WIDTH-1:0]   r_bus_q,   w_bus_d;
    logic                   r_en_q,    w_en_d;
    logic                   w_ready;
    logic                   w_accept;

`ifdef DATA_SYNC_TX_SKID_EN
    logic                   r_skid_full_q, w_skid_full_d;
    logic [BUS_WIDTH-1:0]   r_skid_data_q, w_skid_data_d;

    // The buffer is the only thing that can refuse a word.
    assign w_ready = !r_skid_full_q && !src_rst;
`else
    assign w_ready = (r_state_q == ST_IDLE) && !src_rst;
`endif

    assign w_accept = in_valid && w_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_bus_d   = r_bus_q;
        w_en_d    = r_en_q;
`ifdef DATA_SYNC_TX_SKID_EN
        w_skid_full_d = r_skid_full_q;
        w_skid_data_d = r_skid_data_q;
`endif

        case (r_state_q)
            ST_IDLE: begin
                w_cnt_d = c_CNT_ZERO;
`ifdef DATA_SYNC_TX_SKID_EN
                // A word captured on the last GAP edge is waiting here.
                if (r_skid_full_q) begin
                    w_state_d     = ST_HOLD;
                    w_bus_d       = r_skid_data_q;
                    w_en_d        = 1'b1;
                    w_skid_full_d = 1'b0;
                end else if (w_accept) begin
                    w_state_d = ST_HOLD;
                    w_bus_d   = in_data;
                    w_en_d    = 1'b1;
                end
`else
                if (w_accept) begin
                    w_state_d = ST_HOLD;
                    w_bus_d   = in_data;
                    w_en_d    = 1'b1;
                end
`endif
            end

            ST_HOLD: begin
                if (r_cnt_q == c_HOLD_END) begin
                    w_state_d = ST_GAP;
                    w_cnt_d   = c_CNT_ZERO;
                    w_en_d    = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
`ifdef DATA_SYNC_TX_SKID_EN
                if (w_accept) begin
                    w_skid_full_d = 1'b1;
                    w_skid_data_d = in_data;
                end
`endif
            end

            ST_GAP: begin
                if (r_cnt_q == c_GAP_END) begin
                    w_cnt_d   = c_CNT_ZERO;
                    w_state_d = ST_IDLE;
`ifdef DATA_SYNC_TX_SKID_EN
                    // Skip IDLE when a word is already buffered. in_ready is
                    // low in this case, so no new word can collide with it.
                    if (r_skid_full_q) begin
                        w_state_d     = ST_HOLD;
                        w_bus_d       = r_skid_data_q;
                        w_en_d        = 1'b1;
                        w_skid_full_d = 1'b0;
                    end
`endif
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
`ifdef DATA_SYNC_TX_SKID_EN
                if (w_accept) begin
                    w_skid_full_d = 1'b1;
                    w_skid_data_d = in_data;
                end
`endif
            end

            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = c_CNT_ZERO;
                w_en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= c_CNT_ZERO;
            r_bus_q   <= '0;
            r_en_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_bus_q   <= w_bus_d;
            r_en_q    <= w_en_d;
        end
    end

`ifdef DATA_SYNC_TX_SKID_EN
    // A reset discards any buffered word.
    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            r_skid_full_q <= 1'b0;
            r_skid_data_q <= '0;
        end else begin
            r_skid_full_q <= w_skid_full_d;
            r_skid_data_q <= w_skid_data_d;
        end
    end
`endif

    assign in_ready   = w_ready;
    assign unsync_bus = r_bus_q;
    assign bus_enable = r_en_q;
    assign busy       = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire
